// File: rtl/datapath_pkg.sv
// Shared encodings for the self-sequencing datapath: ALU/shift codes,
// sequencer states and status flag positions.
package datapath_pkg;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADA = 3'd1,
    ST_LOADB = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4
  } state_e;

  localparam int unsigned STAT_N = 2;
  localparam int unsigned STAT_V = 1;
  localparam int unsigned STAT_Z = 0;

endpackage

// File: rtl/regfile_param.sv
// NREG x DATA_W register file: one synchronous write port and two
// asynchronous read ports, cleared by the async reset.
module regfile_param
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Register storage with single write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: one start/done handshake runs LOADA, LOADB,
// EXEC and WB over a shared register file with a host write/debug port.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  NREG   = 8,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mov_imm,
  input  logic [1:0]        alu_op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic              asel,
  input  logic              bsel,
  input  logic              loads,
  input  logic [DATA_W-1:0] imm,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] dbg_num,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] datapath_out,
  output logic [2:0]        status
);

  localparam int MSB = DATA_W - 1;

  function automatic logic [DATA_W-1:0] shift_fn(input logic [1:0] sh,
                                                 input logic [DATA_W-1:0] v);
    case (sh)
      SH_LSL:  shift_fn = {v[MSB-1:0], 1'b0};
      SH_LSR:  shift_fn = {1'b0, v[MSB:1]};
      SH_ASR:  shift_fn = {v[MSB], v[MSB:1]};
      default: shift_fn = v;
    endcase
  endfunction

  // Returns {overflow, result}
  function automatic logic [DATA_W:0] alu_fn(input logic [1:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic              v;
    r = '0;
    v = 1'b0;
    case (op)
      ALU_ADD: begin
        r = a + b;
        v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        r = a + ~b + DATA_W'(1);
        v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
      end
      ALU_AND: r = a & b;
      default: r = ~b;
    endcase
    alu_fn = {v, r};
  endfunction

  state_e            state_q, state_d;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [2:0]        status_q;
  logic              mov_imm_q, asel_q, bsel_q, loads_q;
  logic [1:0]        alu_op_q, shift_q;
  logic [REG_AW-1:0] rn_q, rm_q, rd_q;
  logic [DATA_W-1:0] imm_q;

  logic              rf_we_s;
  logic [REG_AW-1:0] rf_waddr_s;
  logic [DATA_W-1:0] rf_wdata_s;
  logic [REG_AW-1:0] rf_raddr_s;
  logic [DATA_W-1:0] rf_rdata_s;
  logic [DATA_W-1:0] bin_s;
  logic [DATA_W:0]   alu_s;
  logic [2:0]        flags_s;

  regfile_param #(
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (rf_we_s),
    .waddr_i  (rf_waddr_s),
    .wdata_i  (rf_wdata_s),
    .raddr_a_i(rf_raddr_s),
    .rdata_a_o(rf_rdata_s),
    .raddr_b_i(dbg_num),
    .rdata_b_o(dbg_data)
  );

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = mov_imm ? ST_WB : ST_LOADA;
        else       state_d = ST_IDLE;
      end
      ST_LOADA: state_d = ST_LOADB;
      ST_LOADB: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WB;
      ST_WB:    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Host writes only in IDLE, so they never collide with writeback
  always_comb begin
    rf_raddr_s = (state_q == ST_LOADB) ? rm_q : rn_q;
    if (state_q == ST_WB) begin
      rf_we_s    = 1'b1;
      rf_waddr_s = rd_q;
      rf_wdata_s = mov_imm_q ? imm_q : c_q;
    end else begin
      rf_we_s    = (state_q == ST_IDLE) && wr_en;
      rf_waddr_s = wr_num;
      rf_wdata_s = wr_data;
    end
  end

  // Execute-stage operand shaping, ALU and flags
  always_comb begin
    bin_s            = shift_fn(shift_q, bsel_q ? imm_q : b_q);
    alu_s            = alu_fn(alu_op_q, a_q, bin_s);
    flags_s          = 3'b000;
    flags_s[STAT_N]  = alu_s[MSB];
    flags_s[STAT_V]  = alu_s[DATA_W];
    flags_s[STAT_Z]  = (alu_s[MSB:0] == '0);
  end

  // Sequencer, command latch and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      status_q  <= 3'b000;
      mov_imm_q <= 1'b0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
      loads_q   <= 1'b0;
      alu_op_q  <= 2'b00;
      shift_q   <= 2'b00;
      rn_q      <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_q == ST_WB);
      if ((state_q == ST_IDLE) && start) begin
        mov_imm_q <= mov_imm;
        asel_q    <= asel;
        bsel_q    <= bsel;
        loads_q   <= loads;
        alu_op_q  <= alu_op;
        shift_q   <= shift;
        rn_q      <= rn;
        rm_q      <= rm;
        rd_q      <= rd;
        imm_q     <= imm;
      end
      if (state_q == ST_LOADA) a_q <= asel_q ? '0 : rf_rdata_s;
      if (state_q == ST_LOADB) b_q <= rf_rdata_s;
      if (state_q == ST_EXEC) begin
        c_q <= alu_s[MSB:0];
        if (loads_q) status_q <= flags_s;
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign datapath_out = c_q;
  assign status       = status_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed plus randomized bench for datapath_seq (16-bit/8-reg and
// 8-bit/4-reg instances) against an arithmetic reference model.
module tb_datapath_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        d16_start = 1'b0, d16_mov = 1'b0, d16_asel = 1'b0, d16_bsel = 1'b0;
  logic        d16_loads = 1'b0, d16_wr_en = 1'b0;
  logic [1:0]  d16_op = 2'b00, d16_sh = 2'b00;
  logic [2:0]  d16_rn = 3'd0, d16_rm = 3'd0, d16_rd = 3'd0, d16_wr_num = 3'd0, d16_dbg_num = 3'd0;
  logic [15:0] d16_imm = 16'h0, d16_wr_data = 16'h0;
  logic [15:0] d16_dbg_data, d16_out;
  logic        d16_busy, d16_done;
  logic [2:0]  d16_status;

  logic        d8_start = 1'b0, d8_wr_en = 1'b0;
  logic [1:0]  d8_op = 2'b00, d8_sh = 2'b00;
  logic [1:0]  d8_rn = 2'd0, d8_rm = 2'd0, d8_rd = 2'd0, d8_wr_num = 2'd0, d8_dbg_num = 2'd0;
  logic [7:0]  d8_wr_data = 8'h0;
  logic [7:0]  d8_dbg_data, d8_out;
  logic        d8_busy, d8_done;
  logic [2:0]  d8_status;

  datapath_seq #(.DATA_W(16), .NREG(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(d16_start), .mov_imm(d16_mov),
    .alu_op(d16_op), .shift(d16_sh), .rn(d16_rn), .rm(d16_rm), .rd(d16_rd),
    .asel(d16_asel), .bsel(d16_bsel), .loads(d16_loads), .imm(d16_imm),
    .wr_en(d16_wr_en), .wr_num(d16_wr_num), .wr_data(d16_wr_data),
    .dbg_num(d16_dbg_num), .dbg_data(d16_dbg_data), .busy(d16_busy),
    .done(d16_done), .datapath_out(d16_out), .status(d16_status)
  );

  datapath_seq #(.DATA_W(8), .NREG(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(d8_start), .mov_imm(1'b0),
    .alu_op(d8_op), .shift(d8_sh), .rn(d8_rn), .rm(d8_rm), .rd(d8_rd),
    .asel(1'b0), .bsel(1'b0), .loads(1'b1), .imm(8'h00),
    .wr_en(d8_wr_en), .wr_num(d8_wr_num), .wr_data(d8_wr_data),
    .dbg_num(d8_dbg_num), .dbg_data(d8_dbg_data), .busy(d8_busy),
    .done(d8_done), .datapath_out(d8_out), .status(d8_status)
  );

  // Reference state of the 16-bit instance
  longint      m16 [8];
  logic [15:0] mc16 = 16'h0;
  logic [2:0]  mst16 = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Signed-integer view of the operation, result reduced modulo 2^w
  function automatic void model_alu(input int w, input longint a, input longint braw,
                                    input int sh, input int op,
                                    output longint r, output logic [2:0] st);
    longint half, full, modv, bin, sa, sb, sr;
    logic   v;
    modv = longint'(1) << w;
    half = modv / 2;
    case (sh)
      1:       bin = (braw * 2) % modv;
      2:       bin = braw / 2;
      3:       bin = braw / 2 + ((braw >= half) ? half : 0);
      default: bin = braw;
    endcase
    sa = (a   >= half) ? a   - modv : a;
    sb = (bin >= half) ? bin - modv : bin;
    v  = 1'b0;
    case (op)
      0: begin sr = sa + sb; r = (a + bin) % modv;        v = (sr >= half) || (sr < -half); end
      1: begin sr = sa - sb; r = (a + modv - bin) % modv; v = (sr >= half) || (sr < -half); end
      2: r = a & bin;
      default: r = (modv - 1) - bin;
    endcase
    st = {(r >= half), v, (r == 0)};
  endfunction

  task automatic hw16(input logic [2:0] n, input logic [15:0] data);
    d16_wr_en = 1'b1; d16_wr_num = n; d16_wr_data = data;
    @(posedge clk); #1;
    d16_wr_en = 1'b0;
    m16[n] = longint'(data);
  endtask

  task automatic sweep16(input string tag);
    for (int i = 0; i < 8; i++) begin
      d16_dbg_num = 3'(i); #1;
      chk(tag, 32'(d16_dbg_data), 32'(m16[i]));
    end
  endtask

  // One full command; poke drives start+wr_en to R3 while busy
  task automatic cmd16(input bit mov, input logic [1:0] op, input logic [1:0] sh,
                       input logic [2:0] n, input logic [2:0] m, input logic [2:0] d,
                       input bit as, input bit bs, input bit ld, input bit poke,
                       input logic [15:0] im);
    int cyc, lat;
    longint a, b, r;
    logic [2:0] st;
    d16_mov = mov; d16_op = op; d16_sh = sh; d16_rn = n; d16_rm = m; d16_rd = d;
    d16_asel = as; d16_bsel = bs; d16_loads = ld; d16_imm = im; d16_start = 1'b1;
    @(posedge clk); #1;
    d16_start = 1'b0;
    cyc = 0;
    if (mov) begin
      m16[d] = longint'(im);
      lat = 1;
    end else begin
      a = as ? 0 : m16[n];
      b = bs ? longint'(im) : m16[m];
      model_alu(16, a, b, int'(sh), int'(op), r, st);
      mc16 = 16'(r);
      if (ld) mst16 = st;
      m16[d] = r;
      lat = 4;
    end
    if (poke) begin
      d16_start = 1'b1; d16_mov = 1'b1; d16_rd = 3'd3; d16_imm = 16'h1234;
      d16_wr_en = 1'b1; d16_wr_num = 3'd3; d16_wr_data = 16'hAAAA;
      @(posedge clk); #1;
      d16_start = 1'b0; d16_wr_en = 1'b0;
      cyc = 1;
    end
    while (d16_done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("busy_at_done", 32'(d16_busy), 32'd0);
    d16_dbg_num = d; #1;
    chk("wb_reg", 32'(d16_dbg_data), 32'(m16[d]));
    chk("c_reg", 32'(d16_out), 32'(mc16));
    chk("status", 32'(d16_status), 32'(mst16));
    if (poke) begin
      d16_dbg_num = 3'd3; #1;
      chk("busy_write_ignored", 32'(d16_dbg_data), 32'(m16[3]));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(d16_done), 32'd0);
    chk("no_queued_start", 32'(d16_busy), 32'd0);
  endtask

  initial begin
    int dn, cyc;
    logic [7:0] exp8 [4];
    for (int i = 0; i < 8; i++) m16[i] = 0;

    // Reset state
    #12;
    chk("rst_busy", 32'(d16_busy), 32'd0);
    chk("rst_done", 32'(d16_done), 32'd0);
    chk("rst_out", 32'(d16_out), 32'd0);
    chk("rst_status", 32'(d16_status), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    sweep16("rst_regs");

    // ADD with LSL on B
    hw16(3'd0, 16'd7);
    hw16(3'd1, 16'd2);
    cmd16(1'b0, 2'b00, 2'b01, 3'd1, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("tp1_r2", 32'(d16_dbg_data), 32'd16);

    // SUB with LSR, then SUB to zero
    hw16(3'd0, 16'd13);
    hw16(3'd1, 16'd7);
    cmd16(1'b0, 2'b01, 2'b10, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("tp2_r2", 32'(d16_dbg_data), 32'd10);
    cmd16(1'b0, 2'b01, 2'b00, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("tp2_z", 32'(d16_status), 32'b001);

    // Signed overflow and AND clearing V
    hw16(3'd0, 16'h7FFF);
    hw16(3'd1, 16'h0001);
    cmd16(1'b0, 2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("tp3_c", 32'(d16_out), 32'h8000);
    chk("tp3_nvz", 32'(d16_status), 32'b110);
    cmd16(1'b0, 2'b10, 2'b00, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("tp3_and_v", 32'(d16_status[1]), 32'd0);

    // MOV, then start + host write while busy
    cmd16(1'b1, 2'b00, 2'b00, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
    chk("tp4_r5", 32'(d16_dbg_data), 32'hBEEF);
    hw16(3'd3, 16'h5555);
    cmd16(1'b0, 2'b00, 2'b11, 3'd5, 3'd1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1, 16'hF00F);

    // Reset mid-EXEC
    d16_mov = 1'b0; d16_op = 2'b00; d16_sh = 2'b00; d16_rn = 3'd0; d16_rm = 3'd1;
    d16_rd = 3'd4; d16_asel = 1'b0; d16_bsel = 1'b0; d16_loads = 1'b1; d16_start = 1'b1;
    @(posedge clk); #1;
    d16_start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("exec_busy", 32'(d16_busy), 32'd1);
    reset_n = 1'b0; #2; reset_n = 1'b1;
    for (int i = 0; i < 8; i++) m16[i] = 0;
    mc16 = 16'h0; mst16 = 3'b000;
    chk("mid_rst_busy", 32'(d16_busy), 32'd0);
    chk("mid_rst_out", 32'(d16_out), 32'd0);
    chk("mid_rst_status", 32'(d16_status), 32'd0);
    sweep16("mid_rst_regs");
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (d16_done) dn++;
    end
    chk("mid_rst_no_done", 32'(dn), 32'd0);
    hw16(3'd0, 16'd100);
    hw16(3'd1, 16'd58);
    cmd16(1'b0, 2'b01, 2'b00, 3'd0, 3'd1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("post_rst_r4", 32'(d16_dbg_data), 32'd42);

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) hw16(3'($urandom), 16'($urandom));
      cmd16(($urandom_range(0, 5) == 0), 2'($urandom), 2'($urandom), 3'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'b0, 16'($urandom));
    end
    sweep16("rnd_final_regs");

    // 8-bit / 4-register instance: ASR then ADD overflow
    d8_wr_en = 1'b1; d8_wr_num = 2'd0; d8_wr_data = 8'h80;
    @(posedge clk); #1;
    d8_wr_en = 1'b0;
    d8_op = 2'b00; d8_sh = 2'b11; d8_rn = 2'd0; d8_rm = 2'd0; d8_rd = 2'd1; d8_start = 1'b1;
    @(posedge clk); #1;
    d8_start = 1'b0;
    cyc = 0;
    while (d8_done !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8_latency", 32'(cyc), 32'd4);
    chk("w8_out", 32'(d8_out), 32'h40);
    chk("w8_status", 32'(d8_status), 32'b010);
    exp8[0] = 8'h80; exp8[1] = 8'h40; exp8[2] = 8'h00; exp8[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      d8_dbg_num = 2'(i); #1;
      chk("w8_regs", 32'(d8_dbg_data), 32'(exp8[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
Parametrised, self-sequencing successor to the lab datapath. It contains:
- NREG x DATA_W register file
- A/B/C pipeline registers
- shifter, ALU, and a 3-bit status register (N,V,Z)
- an internal FSM that runs a full operation (load A, load B, execute, writeback) from a single start/done handshake, instead of external loada/loadb/loadc/write strobes.

It sits between the instruction decoder and the register-file debug/host port.

Parameters:
DATA_W, 16, datapath and register width (>=4).
NREG, 8, number of general registers (power of 2, >=2).
REG_AW, $clog2(NREG), register index width. Derived localparam, not overridable.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  command request; accepted only when busy=0
mov_imm  in  1  1: write imm to R[rd] (no ALU); 0: ALU operation
alu_op  in  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
shift  in  2  applied to B operand: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
rn  in  REG_AW  A-operand register
rm  in  REG_AW  B-operand register
rd  in  REG_AW  destination register
asel  in  1  1: A operand forced to 0
bsel  in  1  1: B operand = imm (pre-shift), rm ignored
loads  in  1  1: update status at execute
imm  in  DATA_W  immediate value
wr_en  in  1  host direct register write
wr_num  in  REG_AW  host write index
wr_data  in  DATA_W  host write data
dbg_num  in  REG_AW  debug read index
dbg_data  out  DATA_W  combinational R[dbg_num]
busy  out  1  1 when FSM not IDLE
done  out  1  one-cycle pulse after writeback
datapath_out  out  DATA_W  C register
status  out  3  {N,V,Z}, registered

Behaviour:
- Reset (async, any time, including mid-operation):
  - all R[i], A, B, C and status go to 0
  - FSM goes to IDLE; busy=0, done=0
  - an in-flight command is discarded, no writeback.
- FSM states: IDLE, LOADA, LOADB, EXEC, WB.
- IDLE:
  - On an edge with start=1, latch all command fields.
  - Next state is WB if mov_imm=1, else LOADA.
- LOADA: A <= asel ? 0 : R[rn]; next state LOADB.
- LOADB: B <= R[rm]; next state EXEC.
- EXEC:
  - Bin = shift(bsel ? imm : B).
  - C <= ALU(A, Bin).
  - If loads=1, status updates in this state.
  - Next state WB.
- WB:
  - R[rd] <= mov_imm ? imm : C.
  - Next state IDLE.
  - done=1 for exactly the following cycle.
- Latency, start sampled at edge k:
  - ALU command: writeback at edge k+4, done high in cycle k+4..k+5.
  - MOV: writeback at edge k+1, done high in cycle k+1..k+2.
- Back-to-back: a new start is accepted on the same edge on which done is high (FSM is already IDLE).
- Arithmetic is modulo 2^DATA_W. SUB = A + ~Bin + 1.
- Shifts are by 1. ASR replicates the MSB.
- Flags:
  - Z = (result==0).
  - N = result[DATA_W-1].
  - V = signed overflow for ADD/SUB; V=0 for AND/NOT.
- Host port:
  - wr_en is honoured only when busy=0; it is ignored while busy.
  - If start and wr_en occur on the same IDLE edge, the write lands first. LOADA/LOADB then read the new value.
  - WB and host writes therefore never collide.
- start while busy=1 is ignored and does not queue.
- rd equal to rn or rm is legal. The operands are already captured in A/B.
- datapath_out holds C until the next EXEC. status holds until the next EXEC with loads=1.

Decomposition:
- Package datapath_pkg holds:
  - ALU op codes
  - shift codes
  - FSM state enum
  - status bit indices (N=2, V=1, Z=0)
- Sub-module regfile_param (params DATA_W, NREG):
  - one sync write port, two async read ports
  - async active-low reset clears all registers
- Shifter and ALU stay inline as combinational functions.

Test Plan:
- Host writes R0=7, R1=2. Command ADD, rd=2, rn=1, rm=0, shift=01, loads=1 -> R2=16 at edge k+4, done one cycle, status=000.
- Host writes R0=13, R1=7. Command SUB, rd=2, rn=0, rm=1, shift=10 -> R2=10. Then SUB rn=0, rm=0, loads=1 -> R2=0, status Z=1.
- With DATA_W=16: R0=0x7FFF, R1=1. ADD with loads=1 -> C=0x8000, status N=1, V=1, Z=0. Then AND with loads=1 on the same operands -> V=0.
- mov_imm=1, imm=0xBEEF, rd=5 -> R5=0xBEEF at edge k+1, done at k+1. A start plus wr_en to R3 while busy -> both ignored, R3 unchanged.
- ALU command started, reset_n pulsed low in EXEC -> done never asserts, every register and status reads 0, busy=0. A subsequent command executes normally.
- Instantiate with DATA_W=8, NREG=4: R0=0x80, ASR shift with bsel=0, rn=rm=0, ADD -> R[rd]=0x80+0xC0=0x40, V=1. Sweep dbg_num over 0..3 to confirm all registers.
